// File: rtl/bram_pkg.sv
// Shared definitions for the 16x8 block RAM and its read-and-accumulate controller:
// default widths, RAM depth and the controller FSM encoding.
`timescale 1ns/1ps
package bram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bram_sum_reader.sv
// Reads COUNT consecutive BRAM words starting at START_ADDR (wrapping modulo the depth),
// adds them into a running sum with a sticky carry flag, and pulses done when the total is final.
`timescale 1ns/1ps
module bram_sum_reader
  import bram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              c_out
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W:0]   rem_r;
  logic              rd_vld_r;
  logic [DATA_W:0]   acc_s;

  // Widened add of the returned word into the running sum; the top bit is the carry out
  always_comb begin
    acc_s = {1'b0, sum} + {1'b0, bram_rdata};
  end

  // Control FSM, address/remaining counters, read-valid stage and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      rem_r     <= REM_ZERO;
      rd_vld_r  <= 1'b0;
      bram_en   <= 1'b0;
      bram_addr <= {ADDR_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= {DATA_W{1'b0}};
      c_out     <= 1'b0;
    end else begin
      // Data returns one cycle after the BRAM samples an enabled address
      rd_vld_r <= bram_en;
      done     <= 1'b0;
      if (rd_vld_r) begin
        sum   <= acc_s[DATA_W-1:0];
        c_out <= c_out | acc_s[DATA_W];
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            sum   <= {DATA_W{1'b0}};
            c_out <= 1'b0;
            busy  <= 1'b1;
            if (count != REM_ZERO) begin
              bram_en   <= 1'b1;
              bram_addr <= start_addr;
              rem_r     <= count - REM_ONE;
              state_r   <= ISSUE;
            end else begin
              done    <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        ISSUE: begin
          // rem_r counts addresses still to issue after the one currently presented
          if (rem_r == REM_ZERO) begin
            bram_en <= 1'b0;
            state_r <= DRAIN;
          end else begin
            bram_addr <= bram_addr + ADDR_ONE;
            rem_r     <= rem_r - REM_ONE;
          end
        end
        DRAIN: begin
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          bram_en <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
